div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_pkg.sv | 13 +
 rtl/div_sequencer.sv | 119 +++++++++++
 tb/tb_div_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the divider sequencer.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT  = 4;
    localparam int DIV_SETTLE_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_sequencer.sv
// Sequencer around an external combinational divider: latches an operand
// pair, holds it on div_m/div_d for SETTLE cycles, captures the quotient and
// remainder, and presents them with a valid/ready handshake. A zero divisor
// bypasses the divider and returns all-ones / dividend with out_dbz set.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH_DEFAULT,
    parameter int SETTLE = DIV_SETTLE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [WIDTH-1:0] in_dividend,
    output logic [WIDTH-1:0] div_m,
    output logic [WIDTH-1:0] div_d,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_dbz,
    output logic [7:0]       op_count
);

    // Counter is wide enough to hold SETTLE-1; at least one bit.
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] div_m_q;
    logic [WIDTH-1:0] div_d_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [7:0]       op_count_q;

    // FSM with registered handshake flags; divider results sampled only on the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_m_q     <= '0;
            div_d_q     <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            op_count_q  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        div_m_q    <= in_divisor;
                        div_d_q    <= in_dividend;
                        in_ready_q <= 1'b0;
                        if (in_divisor == '0) begin
                            // Divide-by-zero: the divider output is meaningless, skip settling.
                            state_q     <= DONE;
                            quot_q      <= {WIDTH{1'b1}};
                            rem_q       <= in_dividend;
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        quot_q      <= div_q;
                        rem_q       <= div_r;
                        dbz_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        op_count_q  <= op_count_q + 8'd1;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign div_m         = div_m_q;
    assign div_d         = div_d_q;
    assign out_quotient  = quot_q;
    assign out_remainder = rem_q;
    assign out_dbz       = dbz_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a golden combinational divider model.
module tb_div_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_divisor;
    logic [3:0] in_dividend;
    logic [3:0] div_m;
    logic [3:0] div_d;
    logic [3:0] div_q;
    logic [3:0] div_r;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_quotient;
    logic [3:0] out_remainder;
    logic       out_dbz;
    logic [7:0] op_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_sequencer #(.WIDTH(4), .SETTLE(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_divisor    (in_divisor),
        .in_dividend   (in_dividend),
        .div_m         (div_m),
        .div_d         (div_d),
        .div_q         (div_q),
        .div_r         (div_r),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_dbz       (out_dbz),
        .op_count      (op_count)
    );

    // Golden external divider
    assign div_q = (div_m == 4'd0) ? 4'hF  : div_d / div_m;
    assign div_r = (div_m == 4'd0) ? div_d : div_d % div_m;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present an operand pair in IDLE; returns #1 after the accept edge.
    task automatic start_op(input logic [3:0] m, input logic [3:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("accept_ready", {31'd0, in_ready}, 32'd1);
        in_divisor  = m;
        in_dividend = d;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("in_ready_low", {31'd0, in_ready}, 32'd0);
    endtask

    // Count cycles from the accept edge to out_valid and check the result.
    task automatic wait_result(input logic [3:0] m, input logic [3:0] d, input logic [3:0] q,
                               input logic [3:0] r, input logic dbz, input int lat);
        int n;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("latency", n, lat);
        check_val("quotient", {28'd0, out_quotient}, {28'd0, q});
        check_val("remainder", {28'd0, out_remainder}, {28'd0, r});
        check_val("dbz", {31'd0, out_dbz}, {31'd0, dbz});
        check_val("div_m_hold", {28'd0, div_m}, {28'd0, m});
        check_val("div_d_hold", {28'd0, div_d}, {28'd0, d});
        check_val("ready_in_done", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("valid_drop", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic full_op(input logic [3:0] m, input logic [3:0] d, input logic [3:0] q,
                           input logic [3:0] r, input logic dbz, input int lat);
        start_op(m, d);
        wait_result(m, d, q, r, dbz, lat);
        handshake();
    endtask

    initial begin
        logic [7:0] cnt0;
        logic [3:0] m;
        logic [3:0] d;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_divisor  = 4'd0;
        in_dividend = 4'd0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_div_m", {28'd0, div_m}, 32'd0);
        check_val("rst_div_d", {28'd0, div_d}, 32'd0);
        check_val("rst_quot", {28'd0, out_quotient}, 32'd0);
        check_val("rst_op_count", {24'd0, op_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 7/2 accepted on the first edge after reset release
        full_op(4'd2, 4'd7, 4'd3, 4'd1, 1'b0, 3);
        check_val("count_after_1", {24'd0, op_count}, 32'd1);

        // Back-to-back with out_ready held high
        out_ready = 1'b1;
        start_op(4'd4, 4'd9);
        wait_result(4'd4, 4'd9, 4'd2, 4'd1, 1'b0, 3);
        start_op(4'd2, 4'd6);
        wait_result(4'd2, 4'd6, 4'd3, 4'd0, 1'b0, 3);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("count_b2b", {24'd0, op_count}, 32'd3);

        // Divide by zero
        full_op(4'd0, 4'd6, 4'hF, 4'd6, 1'b1, 1);
        check_val("count_dbz", {24'd0, op_count}, 32'd4);

        // Stall in DONE while inputs wiggle
        start_op(4'd3, 4'd11);
        wait_result(4'd3, 4'd11, 4'd3, 4'd2, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            in_valid    = ~in_valid;
            in_divisor  = 4'(i + 5);
            in_dividend = 4'(15 - i);
            @(posedge clk); #1;
            check_val("stall_valid", {31'd0, out_valid}, 32'd1);
            check_val("stall_quot", {28'd0, out_quotient}, 32'd3);
            check_val("stall_rem", {28'd0, out_remainder}, 32'd2);
            check_val("stall_dbz", {31'd0, out_dbz}, 32'd0);
            check_val("stall_ready", {31'd0, in_ready}, 32'd0);
            check_val("stall_div_m", {28'd0, div_m}, 32'd3);
            check_val("stall_count", {24'd0, op_count}, 32'd4);
        end
        in_valid = 1'b0;
        handshake();
        check_val("count_stall", {24'd0, op_count}, 32'd5);

        // Reset in the middle of WAIT
        start_op(4'd2, 4'd7);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_div_m", {28'd0, div_m}, 32'd0);
        check_val("mid_rst_div_d", {28'd0, div_d}, 32'd0);
        check_val("mid_rst_quot", {28'd0, out_quotient}, 32'd0);
        check_val("mid_rst_rem", {28'd0, out_remainder}, 32'd0);
        check_val("mid_rst_dbz", {31'd0, out_dbz}, 32'd0);
        check_val("mid_rst_count", {24'd0, op_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        full_op(4'd2, 4'd7, 4'd3, 4'd1, 1'b0, 3);
        check_val("count_post_rst", {24'd0, op_count}, 32'd1);

        // Run to the op_count wrap with varied operands
        for (int i = 0; i < 255; i++) begin
            m = 4'((i % 15) + 1);
            d = 4'(i * 7);
            full_op(m, d, d / m, d % m, 1'b0, 3);
            if (i == 253) begin
                cnt0 = op_count;
                check_val("count_255", {24'd0, cnt0}, 32'd255);
            end
        end
        check_val("count_wrap", {24'd0, op_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
